// File: rtl/mem_readback_streamer.sv
// rtl/mem_readback_streamer.sv - sweeps a BRAM read port over an address range and streams words with a running checksum
module mem_readback_streamer #(
    parameter int WID_MEM   = 17,
    parameter int DEPTH_MEM = 4096,
    parameter int ADDR_W    = 12,
    parameter int CSUM_W    = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] first_addr_i,
    input  logic [ADDR_W-1:0] last_addr_i,
    output logic [ADDR_W-1:0] raddr_o,
    input  logic [WID_MEM-1:0] rd_data_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [WID_MEM-1:0] m_data_o,
    output logic [ADDR_W-1:0] m_addr_o,
    output logic              m_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CSUM_W-1:0] checksum_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(DEPTH_MEM - 1);
    localparam logic [ADDR_W:0]   ONE      = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W:0]   next_q, next_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [ADDR_W-1:0] last_clamp;

    // Two-stage read pipeline: stage 1 = address on raddr, stage 2 = data on rd_data_i.
    logic              v1_q, l1_q;
    logic              v2_q, l2_q;
    logic [ADDR_W-1:0] a2_q;

    logic [WID_MEM-1:0] fifo_data_q [0:2];
    logic [ADDR_W-1:0]  fifo_addr_q [0:2];
    logic               fifo_last_q [0:2];
    logic [1:0]         wr_ptr_q, rd_ptr_q, count_q;
    logic [CSUM_W-1:0]  checksum_q;

    logic       issue, issue_last, csum_clr, pop;
    logic [2:0] occ;

    assign last_clamp = (last_addr_i > MAX_ADDR) ? MAX_ADDR : last_addr_i;
    assign m_valid_o  = (count_q != 2'd0);
    assign pop        = m_valid_o && m_ready_i;
    // Words that will occupy the FIFO once everything already in flight lands.
    assign occ        = {1'b0, count_q} + {2'b0, v1_q} + {2'b0, v2_q} - {2'b0, pop};

    always_comb begin
        state_d    = state_q;
        next_d     = next_q;
        last_d     = last_q;
        raddr_d    = raddr_q;
        issue      = 1'b0;
        issue_last = 1'b0;
        csum_clr   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    csum_clr = 1'b1;
                    last_d   = last_clamp;
                    if (first_addr_i <= last_clamp) begin
                        issue      = 1'b1;
                        raddr_d    = first_addr_i;
                        next_d     = {1'b0, first_addr_i} + ONE;
                        issue_last = (first_addr_i == last_clamp);
                        state_d    = issue_last ? S_DRAIN : S_RUN;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_RUN: begin
                if (occ < 3'd3) begin
                    issue      = 1'b1;
                    raddr_d    = next_q[ADDR_W-1:0];
                    next_d     = next_q + ONE;
                    issue_last = (next_q == {1'b0, last_q});
                    if (issue_last) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && m_last_o) state_d = S_FIN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            next_q     <= '0;
            last_q     <= '0;
            raddr_q    <= '0;
            v1_q       <= 1'b0;
            l1_q       <= 1'b0;
            v2_q       <= 1'b0;
            l2_q       <= 1'b0;
            a2_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            checksum_q <= '0;
            for (int i = 0; i < 3; i++) begin
                fifo_data_q[i] <= '0;
                fifo_addr_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            next_q  <= next_d;
            last_q  <= last_d;
            raddr_q <= raddr_d;
            v1_q    <= issue;
            l1_q    <= issue_last;
            v2_q    <= v1_q;
            l2_q    <= l1_q;
            a2_q    <= raddr_q;
            if (v2_q) begin
                fifo_data_q[wr_ptr_q] <= rd_data_i;
                fifo_addr_q[wr_ptr_q] <= a2_q;
                fifo_last_q[wr_ptr_q] <= l2_q;
                wr_ptr_q <= (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
            end
            if (pop) rd_ptr_q <= (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
            count_q <= count_q + {1'b0, v2_q} - {1'b0, pop};
            if (csum_clr)
                checksum_q <= '0;
            else if (pop)
                checksum_q <= checksum_q + CSUM_W'(m_data_o);
        end
    end

    assign raddr_o    = raddr_q;
    assign m_data_o   = fifo_data_q[rd_ptr_q];
    assign m_addr_o   = fifo_addr_q[rd_ptr_q];
    assign m_last_o   = fifo_last_q[rd_ptr_q];
    assign busy_o     = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done_o     = (state_q == S_FIN);
    assign checksum_o = checksum_q;

endmodule

// File: tb/tb_mem_readback_streamer.sv
// tb/tb_mem_readback_streamer.sv - randomized bench for mem_readback_streamer against a range/queue reference model
module tb_mem_readback_streamer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [11:0] first_addr = '0;
    logic [11:0] last_addr = '0;
    logic [11:0] raddr;
    logic [16:0] rd_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [16:0] m_data;
    logic [11:0] m_addr;
    logic        m_last;
    logic        busy;
    logic        done;
    logic [31:0] checksum;

    mem_readback_streamer dut (
        .clk_i(clk), .reset_i(reset), .start_i(start),
        .first_addr_i(first_addr), .last_addr_i(last_addr),
        .raddr_o(raddr), .rd_data_i(rd_data),
        .m_valid_o(m_valid), .m_ready_i(m_ready),
        .m_data_o(m_data), .m_addr_o(m_addr), .m_last_o(m_last),
        .busy_o(busy), .done_o(done), .checksum_o(checksum)
    );

    always #5 clk = ~clk;

    logic [16:0] ram [0:4095];
    always @(posedge clk) rd_data <= ram[raddr];

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int s_cyc = 0;
    bit ready_rand = 1'b0;

    int          exp_a [$];
    logic [16:0] exp_d [$];
    int          exp_last = 0;
    logic [31:0] exp_sum = '0;

    int          n_beats = 0;
    bit          got_xfer = 1'b0;
    int          last_xfer = 0;
    bit          fv_seen = 1'b0;
    int          fv_at = 0;
    bit          done_seen = 1'b0;
    int          done_at = 0;
    logic [31:0] done_csum = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        m_ready = ready_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // Beat monitor: compares every handshake with the expected ordered range.
    initial begin
        bit          prev_stall = 1'b0;
        logic [16:0] pd = '0;
        logic [11:0] pa = '0;
        logic        pl = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (busy && got_xfer)
                    check_eq("raddr_ahead", (int'(raddr) - last_xfer) <= 3, 1);
                if (prev_stall) begin
                    check_eq("stall_valid", m_valid, 1);
                    check_eq("stall_data", m_data, pd);
                    check_eq("stall_addr", m_addr, pa);
                    check_eq("stall_last", m_last, pl);
                end
                if (m_valid && !fv_seen) begin
                    fv_seen = 1'b1;
                    fv_at = cyc - s_cyc;
                end
                if (m_valid && m_ready) begin
                    check_eq("beat_expected", exp_a.size() > 0, 1);
                    if (exp_a.size() > 0) begin
                        int          a;
                        logic [16:0] d;
                        a = exp_a.pop_front();
                        d = exp_d.pop_front();
                        check_eq("beat_addr", m_addr, a);
                        check_eq("beat_data", m_data, d);
                        check_eq("beat_last", m_last, a == exp_last);
                    end
                    got_xfer = 1'b1;
                    last_xfer = int'(m_addr);
                    n_beats++;
                end
                prev_stall = m_valid && !m_ready;
                pd = m_data;
                pa = m_addr;
                pl = m_last;
                if (done) begin
                    check_eq("busy_at_done", busy, 0);
                    done_seen = 1'b1;
                    done_at = cyc - s_cyc;
                    done_csum = checksum;
                end
            end
        end
    end

    task automatic start_sweep(input int f, input int l);
        @(posedge clk);
        #1;
        exp_a.delete();
        exp_d.delete();
        exp_sum = '0;
        for (int a = f; a <= l; a++) begin
            exp_a.push_back(a);
            exp_d.push_back(ram[a]);
            exp_sum = exp_sum + 32'(ram[a]);
        end
        exp_last = l;
        n_beats = 0;
        got_xfer = 1'b0;
        fv_seen = 1'b0;
        done_seen = 1'b0;
        first_addr = 12'(f);
        last_addr = 12'(l);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        s_cyc = cyc - 1;
        check_eq("busy_after_start", busy, l >= f);
    endtask

    task automatic wait_done(input int exp_done, input int exp_fv, input int exp_beats);
        int t = 0;
        while (!done_seen && t < 20000) begin
            @(posedge clk);
            t++;
        end
        #1;
        check_eq("done_seen", done_seen, 1);
        if (exp_done >= 0) check_eq("done_cycle", done_at, exp_done);
        if (exp_fv >= 0) check_eq("first_valid_cycle", fv_at, exp_fv);
        check_eq("beat_count", n_beats, exp_beats);
        check_eq("queue_drained", exp_a.size(), 0);
        check_eq("checksum_at_done", done_csum, exp_sum);
        check_eq("checksum_held", checksum, exp_sum);
        check_eq("busy_idle", busy, 0);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_raddr", raddr, 0);
        check_eq("rst_m_valid", m_valid, 0);
        check_eq("rst_m_data", m_data, 0);
        check_eq("rst_m_addr", m_addr, 0);
        check_eq("rst_m_last", m_last, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_checksum", checksum, 0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 17'((i * 3) % 131072);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        reset = 1'b0;

        ready_rand = 1'b0;
        start_sweep(0, 4095);
        wait_done(4099, 3, 4096);

        ready_rand = 1'b1;
        start_sweep(0, 4095);
        wait_done(-1, -1, 4096);

        ready_rand = 1'b0;
        start_sweep(100, 100);
        wait_done(4, 3, 1);

        start_sweep(200, 10);
        wait_done(1, -1, 0);
        check_eq("empty_csum", checksum, 0);

        start_sweep(0, 4095);
        begin
            int t = 0;
            while (n_beats < 50 && t < 1000) begin
                @(posedge clk);
                t++;
            end
            check_eq("reached_word50", n_beats >= 50, 1);
        end
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs();
        reset = 1'b0;
        exp_a.delete();
        exp_d.delete();
        start_sweep(0, 7);
        wait_done(11, 3, 8);

        ready_rand = 1'b1;
        start_sweep(0, 15);
        repeat (5) @(posedge clk);
        #1;
        first_addr = 12'd300;
        last_addr = 12'd310;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(-1, -1, 16);

        for (int it = 0; it < 4; it++) begin
            int f;
            int l;
            for (int i = 0; i < 4096; i++) ram[i] = 17'($urandom);
            f = $urandom_range(0, 4095);
            l = f + $urandom_range(0, 40);
            if (l > 4095) l = 4095;
            if (it == 3) begin
                f = 4090;
                l = 4095;
            end
            ready_rand = (it % 2) == 0;
            start_sweep(f, l);
            wait_done(-1, -1, l - f + 1);
        end

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
